// File: rtl/pbit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pbit_pkg
// Purpose  : Shared types and constants for the p-bit network and its
//            histogram sample collector.
// Revision : 1.0 - initial release
// ============================================================================
package pbit_pkg;

  // State vector width minus one (five p-bits).
  localparam int P = 4;

  // One histogram bin per possible state vector.
  localparam int NUM_BINS = 2 ** (P + 1);

  // The sequencer spends three cycles on each p-bit.
  function automatic int sweep_cycles_for(input int p);
    return 3 * (p + 1);
  endfunction

  // Cycles per full sequencer sweep; shared with the sequencer.
  localparam int SWEEP_CYCLES = sweep_cycles_for(P);

  // Histogram collector control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } hist_state_t;

endpackage
`default_nettype wire

// File: rtl/hist_bin_ram.sv
`default_nettype none
// ============================================================================
// Module   : hist_bin_ram
// Purpose  : Histogram bin storage. One write port that either clears a bin
//            or performs a saturating increment, plus one registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module hist_bin_ram #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              we,
  input  logic              wr_clr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic              full
);

  logic [CNT_W-1:0] r_mem [2**ADDR_W];
  logic [CNT_W-1:0] w_cur;

  // Current content of the write-addressed bin drives the saturation test.
  assign w_cur = r_mem[wr_addr];
  assign full  = &w_cur;

  // Clear or saturating increment; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (!RST && we) begin
      if (wr_clr) begin
        r_mem[wr_addr] <= '0;
      end else if (!full) begin
        r_mem[wr_addr] <= w_cur + CNT_W'(1);
      end
    end
  end

  // Registered read; sees the pre-write value when addresses collide.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_data <= '0;
    end else begin
      rd_data <= r_mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pbit_histogram.sv
`default_nettype none
// ============================================================================
// Module   : pbit_histogram
// Purpose  : Samples the p-bit network state once per sweep, skips a burn-in
//            period and bins the kept states into saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module pbit_histogram #(
  parameter int P            = pbit_pkg::P,
  parameter int CNT_W        = 16,
  parameter int SWEEP_CYCLES = pbit_pkg::SWEEP_CYCLES,
  parameter int BURN_IN      = 2,
  parameter int NUM_SAMPLES  = 1000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [P:0]       state_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             sat,
  input  logic [P:0]       rd_addr,
  output logic [CNT_W-1:0] rd_data
);

  import pbit_pkg::*;

  localparam int c_sc_w    = (SWEEP_CYCLES > 1) ? $clog2(SWEEP_CYCLES) : 1;
  localparam int c_total   = BURN_IN + NUM_SAMPLES;
  localparam int c_sweep_w = $clog2(c_total + 1);

  localparam logic [c_sc_w-1:0]    c_sc_last    = c_sc_w'(SWEEP_CYCLES - 1);
  localparam logic [c_sweep_w-1:0] c_burn_in    = c_sweep_w'(BURN_IN);
  localparam logic [c_sweep_w-1:0] c_last_sweep = c_sweep_w'(c_total - 1);
  localparam logic [P:0]           c_clr_last   = '1;

  hist_state_t          r_state;
  logic [c_sc_w-1:0]    r_sc;
  logic [c_sweep_w-1:0] r_sweeps;
  logic [P:0]           r_clr_idx;
  logic                 r_finish;

  logic                 w_sweep_end;
  logic                 w_bin_en;
  logic                 w_we;
  logic                 w_wr_clr;
  logic [P:0]           w_wr_addr;
  logic                 w_full;

  // Sweep boundary and whether the completed sweep lies past burn-in.
  assign w_sweep_end = (r_state == ST_RUN) && (r_sc == c_sc_last);
  assign w_bin_en    = w_sweep_end && (r_sweeps >= c_burn_in);

  // The single write port is shared by the clear walk and binning.
  assign w_wr_clr  = (r_state == ST_CLEAR);
  assign w_we      = w_wr_clr || w_bin_en;
  assign w_wr_addr = w_wr_clr ? r_clr_idx : state_in;

  // Control FSM with sweep/sample counters and registered status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sat       <= 1'b0;
      r_sc      <= '0;
      r_sweeps  <= '0;
      r_clr_idx <= '0;
      r_finish  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state   <= ST_CLEAR;
            busy      <= 1'b1;
            done      <= 1'b0;
            sat       <= 1'b0;
            r_sc      <= '0;
            r_sweeps  <= '0;
            r_clr_idx <= '0;
            r_finish  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          r_clr_idx <= r_clr_idx + 1'b1;
          if (r_clr_idx == c_clr_last) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (r_finish) begin
            // One cycle after the final binned sweep so its write has landed.
            r_state <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_sc <= (r_sc == c_sc_last) ? '0 : r_sc + c_sc_w'(1);
            if (w_sweep_end) begin
              r_sweeps <= r_sweeps + c_sweep_w'(1);
              if (r_sweeps == c_last_sweep) begin
                r_finish <= 1'b1;
              end
            end
            if (w_bin_en && w_full) begin
              sat <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  hist_bin_ram #(
    .ADDR_W (P + 1),
    .CNT_W  (CNT_W)
  ) u_ram (
    .CLK     (CLK),
    .RST     (RST),
    .we      (w_we),
    .wr_clr  (w_wr_clr),
    .wr_addr (w_wr_addr),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .full    (w_full)
  );

endmodule
`default_nettype wire

// File: tb/tb_pbit_histogram.sv
`default_nettype none
// ============================================================================
// Module   : tb_pbit_histogram
// Purpose  : Self-checking bench for pbit_histogram against a sweep-level
//            reference model of the binning rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pbit_histogram;

  localparam int DONE_A = 33 + (2 + 4) * 15;   // 123
  localparam int DONE_B = 33 + (2 + 8) * 15;   // 183
  localparam int DONE_C = 33 + (2 + 6) * 15;   // 153

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic [4:0]  st_a = '0, rda_a = '0;
  logic        start_a = 1'b0, busy_a, done_a, sat_a;
  logic [15:0] rd_a;
  logic [4:0]  st_b = '0, rda_b = '0;
  logic        start_b = 1'b0, busy_b, done_b, sat_b;
  logic [15:0] rd_b;
  logic [4:0]  st_c = '0, rda_c = '0;
  logic        start_c = 1'b0, busy_c, done_c, sat_c;
  logic [1:0]  rd_c;

  pbit_histogram #(.P(4), .CNT_W(16), .SWEEP_CYCLES(15), .BURN_IN(2), .NUM_SAMPLES(4)) dut_a (
    .CLK(CLK), .RST(RST), .state_in(st_a), .start(start_a), .busy(busy_a),
    .done(done_a), .sat(sat_a), .rd_addr(rda_a), .rd_data(rd_a));
  pbit_histogram #(.P(4), .CNT_W(16), .SWEEP_CYCLES(15), .BURN_IN(2), .NUM_SAMPLES(8)) dut_b (
    .CLK(CLK), .RST(RST), .state_in(st_b), .start(start_b), .busy(busy_b),
    .done(done_b), .sat(sat_b), .rd_addr(rda_b), .rd_data(rd_b));
  pbit_histogram #(.P(4), .CNT_W(2), .SWEEP_CYCLES(15), .BURN_IN(2), .NUM_SAMPLES(6)) dut_c (
    .CLK(CLK), .RST(RST), .state_in(st_c), .start(start_c), .busy(busy_c),
    .done(done_c), .sat(sat_c), .rd_addr(rda_c), .rd_data(rd_c));

  int checks = 0;
  int errors = 0;
  int model[32];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Edge n after the start edge is a binned sample if it is the end of a
  // sweep past burn-in: n = 32 + (2 + k) * 15, k = 1..nsamp.
  function automatic bit is_sample(input int n, input int nsamp);
    int off;
    off = n - 32;
    return (off > 0) && (off % 15 == 0) && (off / 15 > 2) && (off / 15 <= 2 + nsamp);
  endfunction

  // Runs dut_a once (kind 0: constant state 22, kind 1: random), optionally
  // pulsing start at poke edges or RST at rst_at; keeps the model in step.
  task automatic drive_run_a(input int kind, input int rst_at, input int poke1,
                             input int poke2, output int done_edge, output int busy1);
    for (int i = 0; i < 32; i++) model[i] = 0;
    done_edge = -1;
    busy1     = 0;
    start_a   = 1'b1;
    st_a      = 5'($urandom);
    step();
    start_a   = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      st_a    = (kind == 0) ? 5'd22 : 5'($urandom);
      rda_a   = 5'($urandom);
      start_a = (n == poke1) || (n == poke2);
      RST     = (n == rst_at);
      step();
      RST     = 1'b0;
      start_a = 1'b0;
      if (n == 1) busy1 = int'(busy_a);
      if (n == rst_at) return;
      if (is_sample(n, 4) && model[st_a] < 65535) model[st_a]++;
      if (done_a) begin
        done_edge = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_a); end
    checks++; if (sat_a !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", sat_a); end
    checks++; if (rd_a !== 16'd0) begin errors++; $display("FAIL reset_rd_data: got %0d expected 0", rd_a); end
    checks++; if (busy_c !== 1'b0 || done_c !== 1'b0) begin errors++; $display("FAIL reset_c_status: got busy=%b done=%b expected 0 0", busy_c, done_c); end
  endtask

  task automatic test_const_state();
    int de, b1;
    drive_run_a(0, 0, 0, 0, de, b1);
    checks++; if (b1 !== 1) begin errors++; $display("FAIL const_busy_t1: got %0d expected 1", b1); end
    checks++; if (de !== DONE_A) begin errors++; $display("FAIL const_done_edge: got %0d expected %0d", de, DONE_A); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL const_busy_done: got %b expected 0", busy_a); end
    checks++; if (sat_a !== 1'b0) begin errors++; $display("FAIL const_sat: got %b expected 0", sat_a); end
    for (int a = 0; a < 32; a++) begin
      rda_a = 5'(a);
      step();
      checks++;
      if (rd_a !== ((a == 22) ? 16'd4 : 16'd0)) begin
        errors++; $display("FAIL const_bin[%0d]: got %0d expected %0d", a, rd_a, (a == 22) ? 4 : 0);
      end
    end
  endtask

  task automatic test_cycling();
    int de;
    de = -1;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int n = 1; n <= 250; n++) begin
      st_b = (n >= 33) ? 5'(((n - 33) / 15) % 4) : 5'd0;
      step();
      if (done_b) begin de = n; break; end
    end
    checks++; if (de !== DONE_B) begin errors++; $display("FAIL cycle_done_edge: got %0d expected %0d", de, DONE_B); end
    for (int a = 0; a < 32; a++) begin
      rda_b = 5'(a);
      step();
      checks++;
      if (rd_b !== ((a < 4) ? 16'd2 : 16'd0)) begin
        errors++; $display("FAIL cycle_bin[%0d]: got %0d expected %0d", a, rd_b, (a < 4) ? 2 : 0);
      end
    end
  endtask

  task automatic test_saturation();
    int de, k;
    de = -1;
    k  = 0;
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    for (int n = 1; n <= 250; n++) begin
      st_c = 5'd3;
      step();
      if (is_sample(n, 6)) begin
        k++;
        checks++;
        if (sat_c !== (k >= 4)) begin
          errors++; $display("FAIL sat_after_sample%0d: got %b expected %0d", k, sat_c, k >= 4);
        end
      end
      if (done_c) begin de = n; break; end
    end
    checks++; if (de !== DONE_C) begin errors++; $display("FAIL sat_done_edge: got %0d expected %0d", de, DONE_C); end
    rda_c = 5'd3;
    step();
    checks++; if (rd_c !== 2'd3) begin errors++; $display("FAIL sat_bin3: got %0d expected 3", rd_c); end
    rda_c = 5'd0;
    step();
    checks++; if (rd_c !== 2'd0) begin errors++; $display("FAIL sat_bin0: got %0d expected 0", rd_c); end
  endtask

  task automatic test_start_ignored();
    int de, b1;
    drive_run_a(1, 0, 5, 60, de, b1);
    checks++; if (de !== DONE_A) begin errors++; $display("FAIL ign_done_edge: got %0d expected %0d", de, DONE_A); end
    for (int a = 0; a < 32; a++) begin
      rda_a = 5'(a);
      step();
      checks++;
      if (rd_a !== 16'(model[a])) begin errors++; $display("FAIL ign_bin[%0d]: got %0d expected %0d", a, rd_a, model[a]); end
    end
    // Restart from DONE with start held high throughout.
    start_a = 1'b1;
    step();
    checks++; if (done_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++; $display("FAIL restart_from_done: got done=%b busy=%b expected 0 1", done_a, busy_a);
    end
    de = -1;
    for (int n = 1; n <= 200; n++) begin
      st_a = 5'($urandom);
      step();
      if (done_a) begin de = n; break; end
    end
    checks++; if (de !== DONE_A) begin errors++; $display("FAIL held_start_done_edge: got %0d expected %0d", de, DONE_A); end
    step();
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL held_start_rerun: got done=%b expected 0", done_a); end
    start_a = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int de, b1;
    drive_run_a(1, 70, 0, 0, de, b1);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done_a); end
    checks++; if (sat_a !== 1'b0) begin errors++; $display("FAIL midrst_sat: got %b expected 0", sat_a); end
    checks++; if (rd_a !== 16'd0) begin errors++; $display("FAIL midrst_rd_data: got %0d expected 0", rd_a); end
    drive_run_a(1, 0, 0, 0, de, b1);
    checks++; if (de !== DONE_A) begin errors++; $display("FAIL midrst_rerun_done: got %0d expected %0d", de, DONE_A); end
    for (int a = 0; a < 32; a++) begin
      rda_a = 5'(a);
      step();
      checks++;
      if (rd_a !== 16'(model[a])) begin errors++; $display("FAIL midrst_bin[%0d]: got %0d expected %0d", a, rd_a, model[a]); end
    end
  endtask

  task automatic test_read_port();
    int de, exp_v;
    de = -1;
    for (int i = 0; i < 32; i++) model[i] = 0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      st_a  = 5'($urandom_range(0, 3));
      rda_a = (n % 2 == 0) ? st_a : 5'($urandom_range(0, 3));
      step();
      if (n >= 33 && n < DONE_A) begin
        // A collision with the bin written on this edge sees the old count.
        exp_v = model[rda_a];
        checks++;
        if (rd_a !== 16'(exp_v)) begin errors++; $display("FAIL rd_during_run edge%0d: got %0d expected %0d", n, rd_a, exp_v); end
      end
      if (is_sample(n, 4)) model[st_a]++;
      if (done_a) begin de = n; break; end
    end
    checks++; if (de !== DONE_A) begin errors++; $display("FAIL rd_done_edge: got %0d expected %0d", de, DONE_A); end
    for (int a = 0; a < 32; a++) begin
      rda_a = 5'(31 - a);
      step();
      checks++;
      if (rd_a !== 16'(model[31 - a])) begin errors++; $display("FAIL rd_sweep[%0d]: got %0d expected %0d", 31 - a, rd_a, model[31 - a]); end
    end
  endtask

  initial begin
    test_reset();
    test_const_state();
    test_cycling();
    test_saturation();
    test_start_ignored();
    test_reset_mid_run();
    test_read_port();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
